// File: rtl/apb_csr_slave_pkg.sv
// Shared definitions for the APB CSR slave: register offsets, CTRL bit positions,
// reset values, the interrupt vector type and the address decoder.
package apb_csr_slave_pkg;

    localparam logic [7:0] CSR_VERSION_OFS  = 8'h00;
    localparam logic [7:0] CSR_CTRL_OFS     = 8'h04;
    localparam logic [7:0] CSR_STATUS_OFS   = 8'h08;
    localparam logic [7:0] CSR_IRQ_MASK_OFS = 8'h0C;
    localparam logic [7:0] CSR_COUNTER_OFS  = 8'h10;
    localparam logic [7:0] CSR_SCRATCH_OFS  = 8'h20;

    localparam int CTRL_CNT_EN_BIT  = 0;
    localparam int CTRL_CNT_CLR_BIT = 1;

    typedef logic [3:0] irq_vec_t;

    localparam logic [7:0]  CTRL_RST    = 8'h00;
    localparam irq_vec_t    STATUS_RST  = 4'h0;
    localparam irq_vec_t    MASK_RST    = 4'h0;
    localparam logic [31:0] COUNTER_RST = 32'h0;
    localparam logic [31:0] SCRATCH_RST = 32'h0;

    typedef enum logic [2:0] {
        CSR_SEL_NONE,
        CSR_SEL_VERSION,
        CSR_SEL_CTRL,
        CSR_SEL_STATUS,
        CSR_SEL_MASK,
        CSR_SEL_COUNTER,
        CSR_SEL_SCRATCH
    } csr_sel_e;

    // Word-address decode; anything not listed falls through to NONE (reads 0, writes dropped).
    function automatic csr_sel_e csr_decode(input logic [5:0] word, input int num_scratch);
        int w;
        int base;
        w    = int'(word);
        base = int'(CSR_SCRATCH_OFS[7:2]);
        if (w >= base && w < base + num_scratch) return CSR_SEL_SCRATCH;
        case (word)
            CSR_VERSION_OFS[7:2]:  return CSR_SEL_VERSION;
            CSR_CTRL_OFS[7:2]:     return CSR_SEL_CTRL;
            CSR_STATUS_OFS[7:2]:   return CSR_SEL_STATUS;
            CSR_IRQ_MASK_OFS[7:2]: return CSR_SEL_MASK;
            CSR_COUNTER_OFS[7:2]:  return CSR_SEL_COUNTER;
            default:               return CSR_SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/apb_csr_slave_if.sv
// APB3 bus bundle between the CSR master and the CSR slave.
interface apb_csr_slave_if;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport master (output psel, penable, paddr, pwrite, pwdata, input prdata, pready);
    modport slave  (input psel, penable, paddr, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/apb_csr_slave_wait_ctrl.sv
// Access-phase wait-state counter; pready fires once WAIT_CYCLES stalled cycles have elapsed.
module apb_wait_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready
);
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] r_wcnt;
    logic          w_pready;

    assign w_pready = i_psel & i_penable & (r_wcnt == CW'(WAIT_CYCLES));
    assign o_pready = w_pready;

    // Dropping psel aborts the access; completion restarts the count for a back-to-back setup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_wcnt <= '0;
        else if (!i_psel || w_pready) r_wcnt <= '0;
        else if (i_penable)          r_wcnt <= r_wcnt + 1'b1;
    end
endmodule

// File: rtl/apb_csr_slave.sv
// APB3 CSR slave: version, control, W1C status, irq mask, free-running counter, scratch words.
module apb_csr_slave
    import apb_csr_slave_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] VERSION     = 32'h0001_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    apb_csr_slave_if.slave apb,
    input  irq_vec_t       hw_event_i,
    output logic [7:0]     ctrl_o,
    output logic           irq_o
);
    logic        w_pready;
    logic        w_wr;
    logic        w_rd;
    csr_sel_e    w_sel;
    logic [2:0]  w_sidx;
    irq_vec_t    w_w1c;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    logic [7:0]  r_ctrl;
    irq_vec_t    r_status;
    irq_vec_t    r_mask;
    logic [31:0] r_counter;
    logic [31:0] r_scratch [NUM_SCRATCH];
    logic        r_irq;

    apb_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_psel    (apb.psel),
        .i_penable (apb.penable),
        .o_pready  (w_pready)
    );

    assign w_wr          = w_pready & apb.pwrite;
    assign w_rd          = w_pready & ~apb.pwrite;
    assign w_sel         = csr_decode(apb.paddr[7:2], NUM_SCRATCH);
    assign w_sidx        = apb.paddr[4:2];
    assign w_w1c         = (w_wr && w_sel == CSR_SEL_STATUS) ? apb.pwdata[3:0] : '0;
    assign w_unused_addr = ^{apb.paddr[31:8], apb.paddr[1:0]};

    // The clear bit lives for exactly one cycle after the write that set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= CTRL_RST;
        end else if (w_wr && w_sel == CSR_SEL_CTRL) begin
            r_ctrl <= apb.pwdata[7:0];
        end else begin
            r_ctrl[CTRL_CNT_CLR_BIT] <= 1'b0;
        end
    end

    // Event OR comes after the W1C mask so a coincident event keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= STATUS_RST;
            r_mask   <= MASK_RST;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_w1c) | hw_event_i;
            if (w_wr && w_sel == CSR_SEL_MASK) r_mask <= apb.pwdata[3:0];
            r_irq <= |(r_status & r_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_counter <= COUNTER_RST;
        else if (r_ctrl[CTRL_CNT_CLR_BIT]) r_counter <= COUNTER_RST;
        else if (r_ctrl[CTRL_CNT_EN_BIT])  r_counter <= r_counter + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= SCRATCH_RST;
        end else if (w_wr && w_sel == CSR_SEL_SCRATCH) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (w_sidx == 3'(i)) r_scratch[i] <= apb.pwdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            CSR_SEL_VERSION: w_rdata = VERSION;
            CSR_SEL_CTRL: begin
                w_rdata[7:0]             = r_ctrl;
                w_rdata[CTRL_CNT_CLR_BIT] = 1'b0;
            end
            CSR_SEL_STATUS:  w_rdata[3:0] = r_status;
            CSR_SEL_MASK:    w_rdata[3:0] = r_mask;
            CSR_SEL_COUNTER: w_rdata = r_counter;
            CSR_SEL_SCRATCH: begin
                for (int i = 0; i < NUM_SCRATCH; i++)
                    if (w_sidx == 3'(i)) w_rdata = r_scratch[i];
            end
            default: w_rdata = '0;
        endcase
    end

    assign apb.prdata = w_rd ? w_rdata : '0;
    assign apb.pready = w_pready;
    assign ctrl_o     = r_ctrl;
    assign irq_o      = r_irq;
endmodule
